// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce filter and one-hot press pulse per button.
// Optional auto-repeat for REPEAT_MASK buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int              N_BTN        = 3,
  parameter int              DB_CYCLES    = 65536,
  parameter int              REPEAT_DELAY = 25000000,
  parameter int              REPEAT_RATE  = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = 3'b110
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_lvl_o,
  output logic [N_BTN-1:0] press_o
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] lvl_q, lvl_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] press_sel;

`ifdef BTN_AUTOREPEAT_EN
  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_RATE} rep_state_e;

  rep_state_e       rep_state_q, rep_state_d;
  logic [IDX_W-1:0] act_idx_q, act_idx_d;
  logic [27:0]      rcnt_q, rcnt_d;
  logic [27:0]      rep_term;
  logic             act_hold;
  logic             rep_fire;
  logic [N_BTN-1:0] act_onehot;
  logic [IDX_W-1:0] press_idx;
`endif

  always_comb begin
    s1_d = btn_i;
    s2_d = s1_q;
    lvl_d = lvl_q;
    rise = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_TERM) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        lvl_d[i] = s2_q[i];
        cnt_d[i] = '0;
        rise[i]  = s2_q[i];
      end
    end
    // Lowest-index candidate wins; the rest are dropped, not deferred.
    press_sel = rise & (~rise + N_BTN'(1));

`ifdef BTN_AUTOREPEAT_EN
    rep_state_d = rep_state_q;
    act_idx_d   = act_idx_q;
    rcnt_d      = rcnt_q;
    rep_fire    = 1'b0;
    act_hold    = 1'b0;
    act_onehot  = '0;
    press_idx   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (act_idx_q == IDX_W'(i)) begin
        act_onehot[i] = 1'b1;
        act_hold      = lvl_q[i] & lvl_d[i];
      end
      if (press_sel[i]) begin
        press_idx = IDX_W'(i);
      end
    end
    rep_term = (rep_state_q == REP_DELAY) ? 28'(REPEAT_DELAY - 1) : 28'(REPEAT_RATE - 1);

    if (rep_state_q != REP_IDLE) begin
      // A falling level cancels the repeat on the very edge it would fire.
      if (!act_hold) begin
        rep_state_d = REP_IDLE;
        rcnt_d      = '0;
      end else if (rcnt_q == rep_term) begin
        rep_fire    = 1'b1;
        rcnt_d      = '0;
        rep_state_d = REP_RATE;
      end else begin
        rcnt_d = rcnt_q + 28'd1;
      end
    end

    if (press_sel != '0) begin
      press_d = press_sel;
      rcnt_d  = '0;
      if ((press_sel & REPEAT_MASK) != '0) begin
        rep_state_d = REP_DELAY;
        act_idx_d   = press_idx;
      end else begin
        rep_state_d = REP_IDLE;
      end
    end else if (rep_fire) begin
      press_d = act_onehot;
    end else begin
      press_d = '0;
    end
`else
    press_d = press_sel;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef BTN_AUTOREPEAT_EN
      rep_state_q <= REP_IDLE;
      act_idx_q   <= '0;
      rcnt_q      <= '0;
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef BTN_AUTOREPEAT_EN
      rep_state_q <= rep_state_d;
      act_idx_q   <= act_idx_d;
      rcnt_q      <= rcnt_d;
`endif
    end
  end

  assign btn_lvl_o = lvl_q;
  assign press_o   = press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5.
// Expected press pulses are queued as {edge, value}; a negedge monitor pops and compares them.
module tb_btn_conditioner;
  localparam int N_BTN = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] press;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int base;

  logic [34:0] exp_q[$];
  logic [34:0] got;

  btn_conditioner #(
    .N_BTN(N_BTN),
    .DB_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(5),
    .REPEAT_MASK(3'b110)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .btn_i(btn),
    .btn_lvl_o(lvl),
    .press_o(press)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1);
  end

  // driver tasks
  task automatic expect_press(input int at, input logic [N_BTN-1:0] v);
    exp_q.push_back({32'(at), v});
  endtask

  task automatic wait_to(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic check_lvl(input string nm, input logic [N_BTN-1:0] want);
    n_vec++;
    if (lvl !== want) begin
      n_err++;
      $display("FAIL %s: btn_lvl_o=%b expected %b at edge %0d", nm, lvl, want, edge_cnt);
    end
  endtask

  task automatic check_no_press(input string nm);
    n_vec++;
    if (press !== '0) begin
      n_err++;
      $display("FAIL %s: press_o=%b expected 000 at edge %0d", nm, press, edge_cnt);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][34:3]) < edge_cnt) begin
      got = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_press: no pulse, expected %b at edge %0d", got[2:0], int'(got[34:3]));
    end
    if (press !== '0) begin
      n_vec++;
      if (exp_q.size() == 0 || int'(exp_q[0][34:3]) != edge_cnt) begin
        n_err++;
        $display("FAIL unexpected_press: press_o=%b at edge %0d, expected 000", press, edge_cnt);
      end else begin
        got = exp_q.pop_front();
        if (got[2:0] !== press) begin
          n_err++;
          $display("FAIL press_value: press_o=%b expected %b at edge %0d", press, got[2:0], edge_cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    repeat (3) @(negedge clk);
    check_lvl("reset_lvl", 3'b000);
    check_no_press("reset_press");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean press on bit 1, held 40 cycles
    base = edge_cnt + 1;
    btn = 3'b010;
    expect_press(base + 5, 3'b010);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 15; k <= 40; k += 5) expect_press(base + k, 3'b010);
`endif
    wait_to(base + 4);  check_lvl("clean_pre", 3'b000);
    wait_to(base + 5);  check_lvl("clean_rise", 3'b010);
    wait_to(base + 39); btn = 3'b000;
    wait_to(base + 44); check_lvl("clean_rel_pre", 3'b010);
    wait_to(base + 45); check_lvl("clean_rel", 3'b000);
    repeat (4) @(negedge clk);

    // bounce on bit 2: high 3, low 1, then steady
    base = edge_cnt + 1;
    btn = 3'b100;
    expect_press(base + 9, 3'b100);
    wait_to(base + 2);  btn = 3'b000;
    wait_to(base + 3);  btn = 3'b100;
    wait_to(base + 8);  check_lvl("bounce_pre", 3'b000);
    wait_to(base + 9);  check_lvl("bounce_rise", 3'b100);
    wait_to(base + 11); btn = 3'b000;
    wait_to(base + 17); check_lvl("bounce_rel", 3'b000);
    repeat (4) @(negedge clk);

    // glitch one cycle short of DB_CYCLES is ignored
    base = edge_cnt + 1;
    btn = 3'b001;
    wait_to(base + 2);  btn = 3'b000;
    wait_to(base + 10); check_lvl("glitch_short", 3'b000);

    // exactly DB_CYCLES high is accepted, release needs the same
    base = edge_cnt + 1;
    btn = 3'b001;
    expect_press(base + 5, 3'b001);
    wait_to(base + 3);  btn = 3'b000;
    wait_to(base + 5);  check_lvl("min_press_rise", 3'b001);
    wait_to(base + 8);  check_lvl("min_press_hold", 3'b001);
    wait_to(base + 9);  check_lvl("min_press_rel", 3'b000);
    repeat (4) @(negedge clk);

    // simultaneous three buttons: only bit 0 pulses
    base = edge_cnt + 1;
    btn = 3'b111;
    expect_press(base + 5, 3'b001);
    wait_to(base + 5);  check_lvl("simul_lvl", 3'b111);
    wait_to(base + 19); btn = 3'b000;
    wait_to(base + 25); check_lvl("simul_rel", 3'b000);
    repeat (4) @(negedge clk);

    // simultaneous bits 1 and 2: only bit 1 pulses
    base = edge_cnt + 1;
    btn = 3'b110;
    expect_press(base + 5, 3'b010);
    wait_to(base + 5);  check_lvl("pair_lvl", 3'b110);
    wait_to(base + 7);  btn = 3'b000;
    wait_to(base + 13); check_lvl("pair_rel", 3'b000);
    repeat (4) @(negedge clk);

    // staggered presses two cycles apart both pulse
    base = edge_cnt + 1;
    btn = 3'b100;
    expect_press(base + 5, 3'b100);
    expect_press(base + 7, 3'b001);
    wait_to(base + 1);  btn = 3'b101;
    wait_to(base + 7);  check_lvl("stagger_lvl", 3'b101);
    wait_to(base + 11); btn = 3'b000;
    wait_to(base + 17); check_lvl("stagger_rel", 3'b000);
    repeat (4) @(negedge clk);

    // reset mid-hold: re-debounce and pulse again 5 cycles after release of reset
    base = edge_cnt + 1;
    btn = 3'b010;
    expect_press(base + 5, 3'b010);
    expect_press(base + 19, 3'b010);
    wait_to(base + 11); rst_n = 1'b0;
    #1;
    check_lvl("rst_async_lvl", 3'b000);
    wait_to(base + 13);
    check_lvl("rst_hold_lvl", 3'b000);
    check_no_press("rst_hold_press");
    rst_n = 1'b1;
    wait_to(base + 18); check_lvl("rst_redb_pre", 3'b000);
    wait_to(base + 19); check_lvl("rst_redb_rise", 3'b010);
    wait_to(base + 23); btn = 3'b000;
    wait_to(base + 29); check_lvl("rst_redb_rel", 3'b000);
    repeat (4) @(negedge clk);

`ifdef BTN_AUTOREPEAT_EN
    // non-masked bit 0 held: single pulse only
    base = edge_cnt + 1;
    btn = 3'b001;
    expect_press(base + 5, 3'b001);
    wait_to(base + 39); btn = 3'b000;
    wait_to(base + 45); check_lvl("rep_bit0_rel", 3'b000);
    repeat (4) @(negedge clk);

    // bit 2 repeating, bit 1 press lands on a due repeat edge and takes over
    base = edge_cnt + 1;
    btn = 3'b100;
    expect_press(base + 5, 3'b100);
    expect_press(base + 15, 3'b100);
    expect_press(base + 20, 3'b100);
    expect_press(base + 25, 3'b010);
    expect_press(base + 35, 3'b010);
    expect_press(base + 40, 3'b010);
    wait_to(base + 19); btn = 3'b110;
    wait_to(base + 25); check_lvl("preempt_lvl", 3'b110);
    wait_to(base + 37); btn = 3'b000;
    wait_to(base + 43); check_lvl("preempt_rel", 3'b000);
    repeat (4) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_press: no pulse, expected %b at edge %0d", got[2:0], int'(got[34:3]));
    end
    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw push-buttons before the traffic-light controller's `btn_i`.
- Per button: 2-flop synchroniser, then debounce filter, then rising-edge detector.
- Output is a one-hot, single-cycle press pulse, plus optional auto-repeat while add/minus is held.
- Removes the need for the controller's ad-hoc debounce counter; every pulse equals exactly one intended action.

Parameters:
- N_BTN, 3, number of buttons (bit 0 reset, bit 1 add, bit 2 minus).
- DB_CYCLES, 65536, consecutive stable cycles required to accept a level change (legal range 2..2^24).
- REPEAT_DELAY, 25000000, cycles from a press pulse to the first repeat pulse (legal range 1..2^28).
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (legal range 1..2^28).
- REPEAT_MASK, 3'b110, buttons eligible for auto-repeat.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- btn_i  in  N_BTN  raw asynchronous button levels, active-high.
- btn_lvl_o  out  N_BTN  debounced levels.
- press_o  out  N_BTN  one-hot press pulses, one cycle wide; feeds controller `btn_i`.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job):
  - sync flops, debounce counters, btn_lvl_o, press_o, repeat counter all 0.
  - active-button register = none.
- Synchroniser: s1 <= btn_i, s2 <= s1, per bit.
- Debounce, per bit, with counter cnt of width clog2(DB_CYCLES):
  - s2 == lvl: cnt <= 0.
  - s2 != lvl and cnt != DB_CYCLES-1: cnt <= cnt+1.
  - s2 != lvl and cnt == DB_CYCLES-1: lvl <= s2, cnt <= 0.
  - Any glitch back to lvl before terminal count restarts the count; there is no partial credit.
- Latency: btn_i first sampled high at edge k and held high ⇒ btn_lvl_o rises at edge k+DB_CYCLES+1. Release is symmetric.
- Press candidates: bit i is a candidate in the cycle where lvl[i] is about to go 0→1, i.e. registered together with lvl. press_o[i] goes high at the same edge as btn_lvl_o[i] and stays high for exactly one cycle.
- Priority:
  - If several candidates fire on the same edge, only the lowest index is pulsed; the others are dropped, not deferred.
  - press_o is never more than one-hot.
  - A repeat pulse and a new press on the same edge: the new press wins and the repeat is discarded.
- Releases produce no pulse.
- Reset mid-debounce or mid-repeat: all state clears immediately. A button still held after reset deassertion is re-debounced from 0 and pulses once.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - On every emitted press of bit i with REPEAT_MASK[i]=1, the active register <= i and rcnt <= 0; rcnt is a 28-bit repeat counter.
  - A press of a non-masked bit sets the active register to none.
  - While active bit i has lvl=1, rcnt increments each cycle.
  - First repeat: when rcnt reaches REPEAT_DELAY-1, press_o[i] pulses and rcnt <= 0; repeat phase begins.
  - Subsequent repeats: pulse each time rcnt reaches REPEAT_RATE-1, then reset rcnt.
  - lvl[i] falling clears the active register and rcnt in the same cycle; no pulse is emitted on that edge.
- Not defined: the active register, rcnt and repeat logic are absent, and press_o pulses only on debounced rising edges.

Test Plan (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5):
- Clean press: btn_i=3'b010 from edge 0, held 40 cycles, macro off → btn_lvl_o[1] rises at edge 5; press_o=3'b010 for exactly edge 5..6; no further pulses; release gives btn_lvl_o[1]=0 four cycles after the sync delay, with no pulse.
- Bounce: btn_i[2] toggles high 3 cycles, low 1, then high steady from edge 4 → exactly one press_o[2] pulse at edge 9; no pulse earlier.
- Simultaneous: btn_i 3'b000→3'b111 at edge 0 → at edge 5 press_o=3'b001 only, btn_lvl_o=3'b111; no later pulses for bits 1 and 2.
- Auto-repeat (macro on): btn_i[1] held 40 cycles from edge 0 → pulses at edges 5, 15, 20, 25, 30, 35, 40; release stops repeats with no extra pulse. The same test on bit 0 → single pulse at edge 5 only.
- Preempt: bit 2 repeating and bit 1 pressed (debounced) on the edge a repeat was due → only press_o=3'b010 that edge; repeats then follow bit 1.
- Reset mid-hold: rst_ni low 2 cycles at edge 12 while bit 1 held → all outputs 0 during reset; press_o[1] pulses again 5 cycles after release of reset.
